fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch stage controller between the PC register and the IF/ID boundary.
//  Sends the current PC to instruction memory over a req/ack handshake and owns the IF/ID register.
//  A 1-entry skid buffer absorbs an instruction that returns while decode is stalled.
//  Drives the PC register's write enable; keeps at most one memory request outstanding.
// PARAMETERS
//  RESET_PC        32'h0000_3000  reset value of if_pc (matches PC register reset)
//  TIMEOUT_CYCLES  255            wait cycles without ack before fetch_err sets
//  CNT_W           8              timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  pc          in   30  current PC word address [31:2], from PC register
//  pc_wr       out  1   PC write enable (PC <= NPC at next edge)
//  imem_req    out  1   memory request; held with stable imem_addr until ack
//  imem_addr   out  30  word address [31:2]
//  imem_ack    in   1   request completes at the edge where req & ack are both high
//  imem_rdata  in   32  instruction; valid in the ack cycle
//  id_stall    in   1   decode cannot accept; IF/ID register holds
//  flush       in   1   squash IF/ID, skid buffer and any in-flight fetch
//  if_valid    out  1   IF/ID register holds a live instruction
//  if_instr    out  32  IF/ID instruction
//  if_pc       out  30  IF/ID instruction word address [31:2]
//  fetch_err   out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (async): state=FETCH; if_valid=0, if_instr=0, if_pc=RESET_PC[31:2]; skid empty;
//   timeout counter=0; fetch_err=0. While rst is high, imem_req=0 and pc_wr=0.
//  States: FETCH, FULL, DRAIN.
//  FETCH: imem_req=1 and imem_addr=pc (combinational).
//   - On ack with flush=0:
//     - pc_wr=1 in the same cycle.
//     - If the IF/ID register is free (!if_valid | !id_stall), load {if_instr,if_pc} <= {imem_rdata,pc} and set if_valid=1.
//     - Otherwise write the skid buffer and go to FULL.
//   - One-cycle memory gives back-to-back fetches: one instruction per cycle.
//  FULL: imem_req=0, pc_wr=0. When if_valid & !id_stall, skid moves into IF/ID; go to FETCH.
//  Flush has priority over every other event:
//   - At the next edge, if_valid=0 and the skid is emptied. if_instr/if_pc may keep old values.
//   - pc_wr=0 in any flush cycle; redirect is written into PC externally.
//   - Flush in FETCH without ack: latch drain_addr=pc and go to DRAIN.
//   - Flush in FETCH with ack in the same cycle: discard the data and stay in FETCH.
//   - Flush in FULL: go to FETCH.
//  DRAIN: imem_req=1, imem_addr=drain_addr (stable). On ack, discard the data, pc_wr=0, go to FETCH.
//   A further flush in DRAIN has no additional effect.
//  Downstream consumption while in FETCH: if_valid & !id_stall with no new load clears if_valid next edge.
//  Timeout counter:
//   - Increments each cycle imem_req & !imem_ack; clears on ack.
//   - Saturates at TIMEOUT_CYCLES.
//   - On reaching TIMEOUT_CYCLES, fetch_err=1 and stays set until rst. Request stays asserted.
//  Invariants:
//   - At most one outstanding request.
//   - pc_wr count equals the number of instructions delivered to IF/ID or skid.
//   - The skid holds at most one entry and is non-empty only in FULL.
// TESTING
//  1 Reset, pc=0xC00, ack every cycle, no stall -> if_pc 0xC00,0xC01,0xC02 on consecutive cycles;
//    pc_wr high every cycle.
//  2 ack after 3 wait cycles -> imem_req and imem_addr stable for 4 cycles; single pc_wr pulse;
//    if_valid rises 1 cycle after ack.
//  3 id_stall=1 with if_valid=1 while ack arrives -> state FULL, imem_req=0.
//    Drop stall -> skid instr appears in IF/ID next edge, then fetch resumes. No instruction lost or duplicated.
//  4 flush while waiting (ack 2 cycles later), pc changed to 0x2000 -> addr held at old pc until ack;
//    data discarded, pc_wr=0; next request addr=0x2000.
//  5 flush with ack in the same cycle, and flush in FULL -> if_valid=0 next edge, no pc_wr, skid empty.
//  6 No ack for 255 cycles -> fetch_err=1 at cycle 255 and stays high after ack.
//    Assert rst mid-wait -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller. It sits between the PC register
//               and the IF/ID boundary. It issues one req/ack memory request
//               at a time and owns the IF/ID register. A 1-entry skid buffer
//               catches an instruction that returns while decode is stalled.
//               It also drives the PC write enable and raises a sticky flag
//               when a request waits too long for its ack.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pc,
  output logic        pc_wr,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [29:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [29:0]      c_reset_pc = RESET_PC[31:2];

  state_t             r_state;
  logic [29:0]        r_drain_addr;
  logic [31:0]        r_skid_instr;
  logic [29:0]        r_skid_pc;
  logic               r_skid_valid;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_req;
  logic               w_ack;
  logic               w_free;
  logic [CNT_W-1:0]   w_cnt_inc;

  // FETCH and DRAIN are the request-issuing states. FULL waits for decode
  // to take the skid entry. Reset forces the request low right away.
  assign w_req     = !rst && ((r_state == S_FETCH) || (r_state == S_DRAIN));
  assign w_ack     = w_req && imem_ack;
  assign w_free    = !if_valid || !id_stall;
  assign w_cnt_inc = r_cnt + 1'b1;

  assign imem_req  = w_req;
  // A drain keeps the squashed fetch's address stable while the PC moves on.
  assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : pc;
  // The PC advances only when a live fetch completes. A flush cycle never
  // advances it, because the redirect is written into the PC externally.
  assign pc_wr     = (r_state == S_FETCH) && w_ack && !flush;

  // Wait-cycle counter with a sticky error once it saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      fetch_err <= 1'b0;
    end else if (w_ack) begin
      r_cnt <= '0;
    end else if (w_req && (r_cnt != c_timeout)) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == c_timeout) begin
        fetch_err <= 1'b1;
      end
    end
  end

  // Fetch FSM, IF/ID register and skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_drain_addr <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= c_reset_pc;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (flush) begin
            if_valid <= 1'b0;
            // With no ack yet, the request is still in flight. It must be
            // completed and discarded before the redirected fetch starts.
            if (!imem_ack) begin
              r_drain_addr <= pc;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ack) begin
            if (w_free) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end else begin
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= pc;
              r_skid_valid <= 1'b1;
              r_state      <= S_FULL;
            end
          end else if (if_valid && !id_stall) begin
            if_valid <= 1'b0;
          end
        end

        S_FULL: begin
          if (flush) begin
            if_valid     <= 1'b0;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
          end else if (r_skid_valid && w_free) begin
            if_instr     <= r_skid_instr;
            if_pc        <= r_skid_pc;
            if_valid     <= 1'b1;
            r_skid_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // IF/ID is already empty here, so a repeated flush changes nothing.
          if (flush) begin
            if_valid <= 1'b0;
          end
          if (imem_ack) begin
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_skid_valid <= 1'b0;
          if_valid     <= 1'b0;
          r_state      <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. It runs directed scenarios
//               followed by random ack/stall/flush traffic. Results are
//               compared against a transaction-level model: a queue of fetched
//               instructions, a drain flag and a wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] pc;
  logic        pc_wr;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [29:0] if_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  // q[0] is the instruction shown in IF/ID; q[1], if present, is the skid entry.
  logic [61:0] q[$];
  bit          m_drain;
  logic [29:0] m_drain_addr;
  logic [31:0] m_instr;
  logic [29:0] m_pc;
  int          m_wait;
  bit          m_err;

  fetch_ctrl #(
    .RESET_PC      (RESET_PC),
    .TIMEOUT_CYCLES(255),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_wr     (pc_wr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_stall  (id_stall),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [29:0] start_pc);
    q.delete();
    m_drain      = 1'b0;
    m_drain_addr = '0;
    m_instr      = '0;
    m_pc         = RESET_PC[31:2];
    m_wait       = 0;
    m_err        = 1'b0;
    pc           = start_pc;
  endtask

  // Outputs that must hold their reset values while rst is high.
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},      imem_req,  0);
    chk({tag, "_pc_wr"},    pc_wr,     0);
    chk({tag, "_if_valid"}, if_valid,  0);
    chk({tag, "_if_instr"}, if_instr,  0);
    chk({tag, "_if_pc"},    if_pc,     RESET_PC[31:2]);
    chk({tag, "_err"},      fetch_err, 0);
  endtask

  // Runs one clock cycle. This is entered and left just after a falling edge.
  task automatic step(input bit a, input bit st, input bit fl, input logic [29:0] redir);
    bit          e_req, e_wr, take;
    logic [29:0] e_addr, nxt_pc;
    logic [31:0] rdata;
    imem_ack   = a;
    id_stall   = st;
    flush      = fl;
    rdata      = $urandom;
    imem_rdata = rdata;
    #1;
    e_req  = m_drain || (q.size() < 2);
    e_addr = m_drain ? m_drain_addr : pc;
    e_wr   = !m_drain && (q.size() < 2) && a && !fl;
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("pc_wr",     pc_wr,     e_wr);
    chk("if_valid",  if_valid,  q.size() > 0);
    chk("if_instr",  if_instr,  m_instr);
    chk("if_pc",     if_pc,     m_pc);
    chk("fetch_err", fetch_err, m_err);

    // Count waiting cycles. The error is sticky once the limit is reached.
    if (e_req && a) m_wait = 0;
    else if (e_req && m_wait < 255) begin
      m_wait++;
      if (m_wait == 255) m_err = 1'b1;
    end

    if (fl) begin
      if (m_drain) begin
        if (a) m_drain = 1'b0;
      end else if (q.size() < 2 && !a) begin
        m_drain      = 1'b1;
        m_drain_addr = pc;
      end
      q.delete();
    end else if (m_drain) begin
      if (a) m_drain = 1'b0;
    end else begin
      take = (q.size() < 2) && a;
      if (q.size() > 0 && !st) void'(q.pop_front());
      if (take) q.push_back({rdata, pc});
    end
    if (q.size() > 0) {m_instr, m_pc} = q[0];

    nxt_pc = pc;
    if (fl) nxt_pc = redir;
    else if (e_wr) nxt_pc = pc + 30'd1;
    @(negedge clk);
    pc = nxt_pc;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b1;
    id_stall   = 1'b0;
    flush      = 1'b0;
    imem_rdata = '0;
    pc         = 30'hC00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    model_reset(30'hC00);

    // 1: single-cycle memory with no stalls, one instruction per cycle.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("t1_if_pc", if_pc, 32'hC03);

    // 2: three wait cycles, then the ack arrives.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);

    // 3: ack arrives while decode is stalled, which fills the skid; then release.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // 4: flush while waiting, redirect to 0x2000, ack two cycles later.
    step(0, 0, 1, 30'h2000);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t4_if_pc", if_pc, 32'h2000);

    // 5: flush together with ack, then flush while FULL.
    step(1, 0, 0, 0);
    step(1, 0, 1, 30'h400);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 30'h500);
    step(1, 0, 0, 0);

    // 6: no ack for 260 cycles, one ack, then reset during another wait.
    for (int i = 0; i < 260; i++) step(0, 0, 0, 0);
    chk("t6_err", fetch_err, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    imem_ack = 1'b1;
    rst      = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset(30'h100);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 99) < 8), 30'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
